riscv_data_responder: RTL and testbench
=======================================

// Module: riscv_data_responder
// PURPOSE
//  Data-bus responder (slave) for the single-cycle RV32I core's load/store port.
//  Serves word RAM and a memory-mapped IO window: 64-bit machine timer plus status register.
//  Drives the core's irq input from the timer compare.
//  The read path is combinational, because the core consumes load data in the same cycle it issues the address.
// PARAMETERS
//  RAM_BASE   32'h0001_0000  byte base of RAM window (aligned to RAM_WORDS*4)
//  RAM_WORDS  1024           RAM depth in 32-bit words (power of 2)
//  IO_BASE    32'h0002_0000  byte base of 32-byte IO window
//  PRESCALE   1              clocks per mtime increment (>=1)
// PORTS
//  clock        in   1   single clock, all state on posedge
//  reset        in   1   asynchronous, active-low (0 = reset)
//  bus_address  in   32  byte address from core
//  bus_width    in   2   0=byte 1=half 2=word (3=no access)
//  bus_wdata    in   32  store data, value in low bits (byte [7:0], half [15:0])
//  bus_rdata    out  32  load data, addressed item shifted down to bit 0
//  bus_read     in   1   load strobe, combinational response
//  bus_write    in   1   store strobe, committed at posedge
//  irq          out  1   registered timer interrupt to core
// BEHAVIOUR
//  Reset values (reset=0, immediate):
//   - irq=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, status=0
//   - RAM contents not reset; no RAM write while reset=0
//  Decode:
//   - RAM hit: addr in [RAM_BASE, RAM_BASE+4*RAM_WORDS)
//   - IO hit: addr in [IO_BASE, IO_BASE+32)
//   - anything else is unmapped
//  Alignment: half needs addr[0]=0; word needs addr[1:0]=0; else misaligned.
//  Read (comb, 0 latency):
//   - bus_rdata = selected word >> (8*addr[1:0]); upper bits are don't-care to the core but driven as shifted word
//   - bus_rdata=0 when bus_read=0, misaligned, or unmapped
//  RAM write:
//   - byte enables from width and addr[1:0]; bus_wdata low bits replicated to the addressed lane
//   - misaligned or unmapped store: no state change
//  IO map (offset: reg, word access only; narrower stores ignored, narrower loads shifted like RAM):
//   - 0x00 mtime_lo, 0x04 mtime_hi, 0x08 mtimecmp_lo, 0x0C mtimecmp_hi
//   - 0x10 status: bit0 irq_en (RW); bit1 misalign sticky (W1C); bit2 unmapped sticky (W1C); other bits read 0
//   - 0x14..0x1C read 0, writes ignored
//  Sticky errors: set on any misaligned / unmapped access with bus_read|bus_write.
//   - Set has priority over a same-cycle W1C.
//  Timer:
//   - prescaler counts 0..PRESCALE-1; mtime+=1 on the wrap cycle; mtime wraps 2^64-1 -> 0
//   - store to mtime_lo/hi in an increment cycle: the stored half takes the written value; the other half keeps its old value, no carry; prescaler unaffected
//   - irq <= irq_en & (mtime >= mtimecmp), compared on current registers: 1-cycle latency
//   - writing mtimecmp above mtime drops irq on the next edge
//  bus_read & bus_write together:
//   - store commits at the edge
//   - bus_rdata shows pre-store contents
//  Reset mid-operation (async assert):
//   - all registers clear immediately
//   - the in-flight store is lost
// CONFIGURATION
//  BUS_RESPONDER_TIMER_EN:
//   - defined: timer regs 0x00-0x0C present, irq as above
//   - undefined: offsets 0x00-0x0C read 0, writes ignored (not flagged unmapped); irq tied 0; status bit0 reads 0; no timer flops
// TESTING
//  1 sw 0xDEADBEEF @RAM_BASE+4; lbu @+5 -> 0xBE; lb @+7 -> 0xDE in [7:0]; lhu @+6 -> 0xDEAD
//  2 sb 0x12 @RAM_BASE+6 over 0xDEADBEEF -> lw @+4 = 0xDE12BEEF; sh 0x3456 @+4 -> 0xDE123456
//  3 lw @RAM_BASE+2, sh @RAM_BASE+1 -> rdata 0, RAM unchanged, status=0x2; write 0x2 to status -> 0x0
//  4 lw @0x0003_0000 -> rdata 0, status bit2=1; sw there -> no RAM/IO change
//  5 (TIMER_EN, PRESCALE=1) mtimecmp=5, irq_en=1 -> irq rises the cycle after mtime reaches 5; mtimecmp_lo=100 -> irq=0 next cycle
//  6 mtime=64'hFFFF_FFFF_FFFF_FFFF -> next increment 0; assert reset mid-count -> mtime=0, irq=0, mtimecmp all ones at once

Source files
------------

// File: rtl/riscv_data_responder.sv
// Data-bus responder: word RAM plus IO window (timer, status), combinational loads.
// Optional machine timer enabled by defining BUS_RESPONDER_TIMER_EN.
module riscv_data_responder #(
  parameter logic [31:0] RAM_BASE  = 32'h0001_0000,
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] IO_BASE   = 32'h0002_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [1:0]  bus_width,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic        irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   mem [RAM_WORDS];
  logic [AW-1:0] widx;
  logic          ram_hit, io_hit, unmapped;
  logic          valid, access, misal, bad;
  logic [2:0]    off;
  logic [31:0]   io_word, sel;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic          ram_we, io_we, we_st;
  logic          mis_q, mis_d, unm_q, unm_d;
  logic          en_q;

  assign widx     = bus_address[AW+1:2];
  assign ram_hit  = bus_address[31:AW+2] == RAM_BASE[31:AW+2];
  assign io_hit   = bus_address[31:5] == IO_BASE[31:5];
  assign unmapped = !ram_hit && !io_hit;
  assign valid    = bus_width != 2'd3;
  assign access   = (bus_read || bus_write) && valid;
  assign misal    = (bus_width == 2'd1 && bus_address[0])
                 || (bus_width == 2'd2 && bus_address[1:0] != 2'b00);
  assign bad      = misal || unmapped;
  assign off      = bus_address[4:2];

`ifdef BUS_RESPONDER_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   cmp_q, cmp_d;
  logic          irq_q, irq_d;
  logic          en_d, tick;
`else
  assign en_q = 1'b0;
`endif

  always_comb begin
    io_word = '0;
    case (off)
`ifdef BUS_RESPONDER_TIMER_EN
      3'd0: io_word = mtime_q[31:0];
      3'd1: io_word = mtime_q[63:32];
      3'd2: io_word = cmp_q[31:0];
      3'd3: io_word = cmp_q[63:32];
`endif
      3'd4: io_word = {29'd0, unm_q, mis_q, en_q};
      default: io_word = '0;
    endcase
  end

  assign sel = ram_hit ? mem[widx] : io_word;
  assign bus_rdata = (bus_read && valid && !bad)
                   ? sel >> {bus_address[1:0], 3'b000} : '0;

  always_comb begin
    be = 4'b1111;
    wd = bus_wdata;
    unique case (1'b1)
      bus_width == 2'd0: begin
        be = 4'b0001 << bus_address[1:0];
        wd = {4{bus_wdata[7:0]}};
      end
      bus_width == 2'd1: begin
        be = bus_address[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = bus_wdata;
      end
    endcase
  end

  assign ram_we = bus_write && valid && !misal && ram_hit && reset;

  // RAM contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign io_we = bus_write && bus_width == 2'd2 && io_hit
              && bus_address[1:0] == 2'b00;
  assign we_st = io_we && off == 3'd4;

  // A new error wins over a same-cycle clear.
  assign mis_d = (mis_q && !(we_st && bus_wdata[1])) || (access && misal);
  assign unm_d = (unm_q && !(we_st && bus_wdata[2])) || (access && unmapped);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mis_q <= 1'b0;
      unm_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
      unm_q <= unm_d;
    end
  end

`ifdef BUS_RESPONDER_TIMER_EN
  assign tick  = presc_q == PW'(PRESCALE - 1);
  assign en_d  = we_st ? bus_wdata[0] : en_q;
  assign irq_d = en_q && (mtime_q >= cmp_q);

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    cmp_d   = cmp_q;
    if (io_we) begin
      case (off)
        3'd0: mtime_d = {mtime_q[63:32], bus_wdata};
        3'd1: mtime_d = {bus_wdata, mtime_q[31:0]};
        3'd2: cmp_d   = {cmp_q[63:32], bus_wdata};
        3'd3: cmp_d   = {bus_wdata, cmp_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      mtime_q <= '0;
      cmp_q   <= '1;
      en_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_data_responder.sv
// Directed bench for riscv_data_responder with an expected-load queue.
// Timer checks compile in when BUS_RESPONDER_TIMER_EN is defined.
module tb_riscv_data_responder;

  localparam logic [31:0] RB = 32'h0001_0000;
  localparam logic [31:0] IB = 32'h0002_0000;
  localparam logic [31:0] UA = 32'h0003_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bus_address;
  logic [1:0]  bus_width;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_read;
  logic        bus_write;
  logic        irq;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  riscv_data_responder dut (
    .clock       (clock),
    .reset       (reset),
    .bus_address (bus_address),
    .bus_width   (bus_width),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .irq         (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_cmp(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, obs, e);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] w,
                    input logic [31:0] d);
    bus_address = a;
    bus_width   = w;
    bus_wdata   = d;
    bus_write   = 1'b1;
    @(negedge clock);
    bus_write   = 1'b0;
    bus_width   = 2'd3;
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] w,
                    input logic [31:0] e, input string tag);
    bus_address = a;
    bus_width   = w;
    bus_read    = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    sb_cmp(bus_rdata);
    @(negedge clock);
    bus_read  = 1'b0;
    bus_width = 2'd3;
  endtask

  initial begin
    reset       = 1'b0;
    bus_address = '0;
    bus_width   = 2'd3;
    bus_wdata   = '0;
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    ld(IB + 32'h10, 2'd2, 32'h0, "reset_status");
    ld(IB + 32'h0, 2'd2, 32'h0, "reset_mtime_lo");
    reset = 1'b1;
    @(negedge clock);

    st(RB + 4, 2'd2, 32'hDEAD_BEEF);
    ld(RB + 4, 2'd2, 32'hDEAD_BEEF, "lw_4");
    ld(RB + 5, 2'd0, 32'h00DE_ADBE, "lbu_5");
    ld(RB + 7, 2'd0, 32'h0000_00DE, "lb_7");
    ld(RB + 6, 2'd1, 32'h0000_DEAD, "lhu_6");

    st(RB + 6, 2'd0, 32'hFFFF_FF12);
    ld(RB + 4, 2'd2, 32'hDE12_BEEF, "sb_merge");
    st(RB + 4, 2'd1, 32'h0000_3456);
    ld(RB + 4, 2'd2, 32'hDE12_3456, "sh_merge");

    bus_address = RB + 4;
    bus_width   = 2'd2;
    #1;
    chk("rdata_no_read", bus_rdata, 32'h0);
    @(negedge clock);

    st(RB + 0, 2'd2, 32'h1122_3344);
    ld(RB + 2, 2'd2, 32'h0, "lw_misaligned");
    st(RB + 1, 2'd1, 32'h0000_AAAA);
    ld(RB + 0, 2'd2, 32'h1122_3344, "sh_misaligned_nochange");
    ld(IB + 32'h10, 2'd2, 32'h2, "status_misalign");
    st(IB + 32'h10, 2'd2, 32'h2);
    ld(IB + 32'h10, 2'd2, 32'h0, "status_w1c");

    ld(UA, 2'd2, 32'h0, "lw_unmapped");
    ld(IB + 32'h10, 2'd2, 32'h4, "status_unmapped");
    st(UA, 2'd2, 32'h0000_0055);
    ld(RB + 0, 2'd2, 32'h1122_3344, "sw_unmapped_no_alias");
    st(IB + 32'h10, 2'd2, 32'h4);
    ld(IB + 32'h10, 2'd2, 32'h0, "status_w1c_unm");

    st(RB + 8, 2'd2, 32'h0000_0001);
    bus_address = RB + 8;
    bus_width   = 2'd2;
    bus_wdata   = 32'h7777_8888;
    bus_read    = 1'b1;
    bus_write   = 1'b1;
    exp_q.push_back(32'h0000_0001);
    tag_q.push_back("rw_pre_store");
    #1;
    sb_cmp(bus_rdata);
    @(negedge clock);
    bus_read  = 1'b0;
    bus_write = 1'b0;
    ld(RB + 8, 2'd2, 32'h7777_8888, "rw_post_store");

    st(IB + 32'h10, 2'd0, 32'h0000_0001);
    ld(IB + 32'h10, 2'd2, 32'h0, "status_narrow_ignored");
    ld(IB + 32'h14, 2'd2, 32'h0, "io_0x14_zero");

`ifdef BUS_RESPONDER_TIMER_EN
    st(IB + 32'h0C, 2'd2, 32'h0);
    st(IB + 32'h10, 2'd2, 32'h1);
    st(IB + 32'h04, 2'd2, 32'h0);
    st(IB + 32'h00, 2'd2, 32'h0);
    st(IB + 32'h08, 2'd2, 32'h5);
    repeat (4) @(negedge clock);
    chk("irq_before_cmp", {31'd0, irq}, 32'd0);
    @(negedge clock);
    chk("irq_at_cmp", {31'd0, irq}, 32'd1);
    ld(IB + 32'h00, 2'd2, 32'h6, "mtime_count");
    st(IB + 32'h08, 2'd2, 32'd100);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clock);
    chk("irq_drop", {31'd0, irq}, 32'd0);

    st(IB + 32'h04, 2'd2, 32'hFFFF_FFFF);
    st(IB + 32'h00, 2'd2, 32'hFFFF_FFFF);
    ld(IB + 32'h00, 2'd2, 32'hFFFF_FFFF, "mtime_max_lo");
    ld(IB + 32'h04, 2'd2, 32'h0, "mtime_wrap_hi");
    st(IB + 32'h08, 2'd2, 32'h0);
    st(IB + 32'h0C, 2'd2, 32'h0);
    @(negedge clock);
    chk("irq_pre_reset", {31'd0, irq}, 32'd1);
`else
    st(IB + 32'h00, 2'd2, 32'h0000_1234);
    ld(IB + 32'h00, 2'd2, 32'h0, "notimer_mtime_zero");
    st(IB + 32'h10, 2'd2, 32'h1);
    ld(IB + 32'h10, 2'd2, 32'h0, "notimer_status");
    chk("notimer_irq", {31'd0, irq}, 32'd0);
`endif

    st(RB + 12, 2'd2, 32'hCAFE_0000);
    ld(UA, 2'd0, 32'h0, "unmapped_pre_reset");
    bus_address = RB + 12;
    bus_width   = 2'd2;
    bus_wdata   = 32'hBADB_AD00;
    bus_write   = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("async_irq", {31'd0, irq}, 32'd0);
    @(negedge clock);
    bus_write = 1'b0;
    ld(IB + 32'h10, 2'd2, 32'h0, "async_status");
`ifdef BUS_RESPONDER_TIMER_EN
    ld(IB + 32'h00, 2'd2, 32'h0, "async_mtime_lo");
    ld(IB + 32'h04, 2'd2, 32'h0, "async_mtime_hi");
    ld(IB + 32'h08, 2'd2, 32'hFFFF_FFFF, "async_cmp_lo");
    ld(IB + 32'h0C, 2'd2, 32'hFFFF_FFFF, "async_cmp_hi");
`endif
    reset = 1'b1;
    @(negedge clock);
    ld(RB + 12, 2'd2, 32'hCAFE_0000, "store_lost_in_reset");
    chk("irq_after_reset", {31'd0, irq}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
